// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared definitions for the MEM/WB stage.
//   - load-type codes carried from the memory stage
//   - stall-vector bit positions and their Stop/NoStop levels
//   - register-file write-enable levels, the zero word and bus widths
package mem_wb_stage_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    // Codes 6 and 7 are not listed; the aligner treats them like LD_NONE.
    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5
    } ld_type_e;

    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic Stop          = 1'b1;
    localparam logic NoStop        = 1'b0;
    localparam logic WriteEnable   = 1'b1;
    localparam logic WriteDisable  = 1'b0;

    localparam logic [RegBus-1:0] ZeroWord = '0;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// mem_wb_stage_load_align: combinational big-endian load aligner.
// Ports:
//   ldtype   in  3   load type (ld_type_e encoding, 6/7 = none)
//   addr_lo  in  2   low two bits of the byte address
//   rdata    in  DW  data-bus read word
//   wdata    in  DW  non-load result, passed through for non-loads
//   data     out DW  aligned / extended write-back data (0 if misaligned)
//   misalign out 1   halfword at odd address or word not on a 4-byte boundary
module mem_wb_stage_load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    ldtype,
    input  logic [1:0]    addr_lo,
    input  logic [DW-1:0] rdata,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] data,
    output logic          misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Big-endian: byte address 0 is the most significant byte of the word.
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[31:24];
            2'd1:    byte_sel = rdata[23:16];
            2'd2:    byte_sel = rdata[15:8];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        data     = wdata;
        misalign = 1'b0;
        case (ldtype)
            LD_LB:  data = {{(DW-8){byte_sel[7]}}, byte_sel};
            LD_LBU: data = {{(DW-8){1'b0}}, byte_sel};
            LD_LH, LD_LHU: begin
                if (addr_lo[0]) begin
                    misalign = 1'b1;
                    data     = '0;
                end else if (ldtype == LD_LH) begin
                    data = {{(DW-16){half_sel[15]}}, half_sel};
                end else begin
                    data = {{(DW-16){1'b0}}, half_sel};
                end
            end
            LD_LW: begin
                if (addr_lo != 2'd0) begin
                    misalign = 1'b1;
                    data     = '0;
                end else begin
                    data = rdata;
                end
            end
            default: data = wdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load-data alignment.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall[5:0]          bit 4 = MEM stalled, bit 5 = WB stalled
//   flush               kills the instruction entering WB
//   mem_we/waddr/wdata  memory-stage register write
//   mem_ldtype/addr_lo  load type and low address bits
//   mem_rdata           data-bus read word
//   mem_whilo/hi/lo     HI/LO write
//   wb_we/waddr/wdata   registered register-file write port
//   wb_whilo/hi/lo      registered HI/LO write
//   wb_misalign         one-cycle pulse when a misaligned load is squashed
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    stall,
    input  logic          flush,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_waddr,
    input  logic [DW-1:0] mem_wdata,
    input  logic [2:0]    mem_ldtype,
    input  logic [1:0]    mem_addr_lo,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_whilo,
    input  logic [DW-1:0] mem_hi,
    input  logic [DW-1:0] mem_lo,
    output logic          wb_we,
    output logic [AW-1:0] wb_waddr,
    output logic [DW-1:0] wb_wdata,
    output logic          wb_whilo,
    output logic [DW-1:0] wb_hi,
    output logic [DW-1:0] wb_lo,
    output logic          wb_misalign
);

    logic [DW-1:0] align_data;
    logic          align_misalign;
    logic          bubble;
    logic          advance;
    logic          stall_unused;

    // Earlier-stage stall bits are not used here.
    assign stall_unused = ^stall[3:0];

    mem_wb_stage_load_align #(.DW(DW)) u_align (
        .ldtype   (mem_ldtype),
        .addr_lo  (mem_addr_lo),
        .rdata    (mem_rdata),
        .wdata    (mem_wdata),
        .data     (align_data),
        .misalign (align_misalign)
    );

    // MEM stalled while WB runs: WB must receive a bubble, not a duplicate.
    assign bubble  = (stall[STALL_MEM] == Stop) && (stall[STALL_WB] == NoStop);
    assign advance = (stall[STALL_MEM] == NoStop);

    // MEM -> WB register
    always_ff @(posedge clk) begin
        if (rst || flush || bubble) begin
            wb_we       <= WriteDisable;
            wb_waddr    <= '0;
            wb_wdata    <= '0;
            wb_whilo    <= WriteDisable;
            wb_hi       <= '0;
            wb_lo       <= '0;
            wb_misalign <= 1'b0;
        end else if (advance) begin
            // A misaligned load drops its register write but HI/LO still pass.
            wb_we       <= mem_we && !align_misalign;
            wb_waddr    <= mem_waddr;
            wb_wdata    <= align_data;
            wb_whilo    <= mem_whilo;
            wb_hi       <= mem_hi;
            wb_lo       <= mem_lo;
            wb_misalign <= align_misalign;
        end else begin
            // Hold: keep the write pending, but report misalignment only once.
            wb_misalign <= 1'b0;
        end
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and load-data aligner. Sits between the memory-access stage and the register file write port (we/waddr/wdata) and the HI/LO register. Captures the memory-stage result each cycle, sign- or zero-extends and aligns big-endian load data, and honours the core's stall/flush controls. Its registered outputs drive the register file directly.

## Interface
Parameters:
- DW, 32, data width (register and bus word)
- AW, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  6  pipeline stall vector; bit 4 = MEM stalled, bit 5 = WB stalled (1 = stop)
- flush  in  1  exception flush; kills the instruction entering WB
- mem_we  in  1  memory-stage register write enable
- mem_waddr  in  AW  destination register
- mem_wdata  in  DW  ALU/store-path result (used when not a load)
- mem_ldtype  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; 6/7 treated as none
- mem_addr_lo  in  2  low two bits of the load byte address
- mem_rdata  in  DW  data-bus read word
- mem_whilo  in  1  HI/LO write enable
- mem_hi, mem_lo  in  DW  HI/LO values
- wb_we  out  1  to register file we
- wb_waddr  out  AW  to register file waddr
- wb_wdata  out  DW  to register file wdata
- wb_whilo  out  1  HI/LO write enable
- wb_hi, wb_lo  out  DW  HI/LO write data
- wb_misalign  out  1  one-cycle pulse: misaligned load was squashed

## Operation
- All outputs registered; reset value of every output is 0.
- Update priority each posedge: rst > flush > bubble > advance > hold.
  - flush=1: load bubble (all outputs 0).
  - stall[4]=1 and stall[5]=0: load bubble.
  - stall[4]=0: advance, capture the aligned memory-stage values.
  - otherwise (stall[4]=1, stall[5]=1): hold all outputs unchanged; wb_misalign forced 0 after its first cycle.
- Write-data select (mem_ldtype):
  - 0/6/7: mem_wdata.
  - LB/LBU: byte at addr_lo 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0]. LB sign-extends; LBU zero-extends.
  - LH/LHU: addr_lo 0→[31:16], 2→[15:0]. LH sign-extends; LHU zero-extends.
  - LW: full word, addr_lo must be 0.
- Misalignment: halfword with addr_lo[0]=1, or LW with addr_lo≠0. On advance, wb_we=0, wb_wdata=0, wb_misalign=1. HI/LO fields still pass through.
- wb_misalign is 0 on every non-advance cycle.
- mem_waddr=0 with mem_we=1 passes through unchanged; the register file discards the write.

## Timing
- Latency: one cycle from memory-stage inputs to wb_* outputs.
- The register file samples wb_we/wb_waddr/wb_wdata on the following posedge. Its same-cycle read forwarding covers the ID-stage hazard, so this block needs no bypass.
- Reset mid-stall: rst wins; outputs 0 next cycle.
- flush coincident with stall: flush wins (bubble).
- No combinational path from any input to any output.

## Structure
- Shared defines file holds: ld-type codes (LD_NONE..LD_LW), stall-bit indices, Stop/NoStop, WriteEnable, ZeroWord, RegAddrBus/RegBus widths.
- Sub-module load_align: purely combinational. Inputs ldtype, addr_lo, rdata, wdata; outputs data and misalign. The top level holds only the pipeline register and the stall/flush priority.

## Test plan
- Reset: hold rst 2 cycles with random inputs → all outputs 0; release with mem_we=1, waddr=5, wdata=0x12345678, ldtype=0 → next cycle wb_we=1, waddr=5, wdata=0x12345678.
- Byte loads: rdata=0x80FF7F01; LB at addr_lo 0..3 → 0xFFFFFF80, 0xFFFFFFFF, 0x0000007F, 0x00000001. LBU at addr_lo 0 → 0x00000080.
- Halfword/word: rdata=0x8001FFFE; LH at addr_lo 0 → 0xFFFF8001; LHU at addr_lo 2 → 0x0000FFFE; LW → 0x8001FFFE.
- Misalign: LH at addr_lo 1 and LW at addr_lo 2 → wb_we=0, wb_wdata=0, wb_misalign=1 for exactly one cycle. With mem_whilo=1, hi=0xA → wb_whilo=1, wb_hi=0xA.
- Stall/flush: stall=6'b010000 → bubble next cycle. stall=6'b110000 for 3 cycles → outputs held constant. flush=1 with stall=0 → bubble.
- Priority: rst=1, flush=1 and stall[4]=0 together → outputs 0. mem_waddr=0 with mem_we=1 → wb_waddr=0, wb_we=1 passed through.
